// File: rtl/operand_forward.sv
// Operand forwarding between register-file read ports and ALU inputs: replaces stale
// read data with the youngest recorded writeback, forces x0 to zero, counts forwards.
module operand_forward #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_enable,
  input  logic [4:0]      rs1_sf,
  input  logic [4:0]      rs2_sf,
  input  logic            wr_en_s3,
  input  logic [4:0]      rd_s3,
  input  logic [XLEN-1:0] wr_data_s3,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            cnt_clear,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic [15:0]     fwd_count
);

  logic [4:0]        rs1_q, rs2_q;
  logic [DEPTH-1:0]  slot_valid_q;
  logic [ADDR_W-1:0] slot_idx_q  [DEPTH];
  logic [XLEN-1:0]   slot_data_q [DEPTH];
  logic [15:0]       fwd_count_q, fwd_count_d;
  logic [16:0]       cnt_sum;
  logic [XLEN:0]     sel_a, sel_b;

  // Returns {forwarded, data}; scanning oldest-to-youngest lets the youngest match win.
  function automatic logic [XLEN:0] pick_operand(input logic [4:0]      rs,
                                                 input logic [XLEN-1:0] rf);
    logic [XLEN:0] res;
    res = {1'b0, rf};
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (slot_valid_q[i] && (slot_idx_q[i] == rs[ADDR_W-1:0])) begin
        res = {1'b1, slot_data_q[i]};
      end
    end
    if (rs == 5'd0) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    sel_a = pick_operand(rs1_q, rf_data_a);
    sel_b = pick_operand(rs2_q, rf_data_b);
  end

  assign fwd_a     = sel_a[XLEN];
  assign op_a      = sel_a[XLEN-1:0];
  assign fwd_b     = sel_b[XLEN];
  assign op_b      = sel_b[XLEN-1:0];
  assign fwd_count = fwd_count_q;

  always_comb begin
    cnt_sum     = {1'b0, fwd_count_q} + 17'(fwd_a) + 17'(fwd_b);
    fwd_count_d = fwd_count_q;
    if (cnt_clear) begin
      fwd_count_d = '0;
    end else if (cnt_sum[16]) begin
      fwd_count_d = 16'hFFFF;
    end else begin
      fwd_count_d = cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      slot_valid_q <= '0;
      fwd_count_q  <= '0;
    end else if (clk_enable) begin
      rs1_q       <= rs1_sf;
      rs2_q       <= rs2_sf;
      fwd_count_q <= fwd_count_d;
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        slot_valid_q[i] <= slot_valid_q[i-1];
      end
      slot_valid_q[0] <= wr_en_s3 && (rd_s3 != 5'd0);
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        slot_idx_q[i]  <= slot_idx_q[i-1];
        slot_data_q[i] <= slot_data_q[i-1];
      end
      slot_idx_q[0]  <= rd_s3[ADDR_W-1:0];
      slot_data_q[0] <= wr_data_s3;
    end
  end

endmodule

// File: tb/tb_operand_forward.sv
// Bench for operand_forward: directed hazard/x0/alias/stall/saturation cases plus
// randomized traffic, all checked against a queue-based writeback history model.
module tb_operand_forward;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_enable = 1'b1;
  logic [4:0]  rs1_sf = '0, rs2_sf = '0, rd_s3 = '0;
  logic        wr_en_s3 = 1'b0, cnt_clear = 1'b0;
  logic [31:0] wr_data_s3 = '0, rf_data_a = '0, rf_data_b = '0;
  logic [31:0] op_a, op_b;
  logic        fwd_a, fwd_b;
  logic [15:0] fwd_count;

  operand_forward #(.XLEN(32), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_enable (clk_enable),
    .rs1_sf     (rs1_sf),
    .rs2_sf     (rs2_sf),
    .wr_en_s3   (wr_en_s3),
    .rd_s3      (rd_s3),
    .wr_data_s3 (wr_data_s3),
    .rf_data_a  (rf_data_a),
    .rf_data_b  (rf_data_b),
    .cnt_clear  (cnt_clear),
    .op_a       (op_a),
    .op_b       (op_b),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_count  (fwd_count)
  );

  always #5 clk = ~clk;

  // Model: list of recent writebacks, youngest first.
  typedef struct packed {
    logic        v;
    logic [3:0]  idx;
    logic [31:0] d;
  } ent_t;

  ent_t        hist[$];
  logic [4:0]  m_rs1, m_rs2;
  int          m_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void m_pick(input logic [4:0] rs, input logic [31:0] rf,
                                 output logic [31:0] op, output logic f);
    op = rf;
    f  = 1'b0;
    if (rs == 5'd0) begin
      op = '0;
      return;
    end
    foreach (hist[i]) begin
      if (hist[i].v && hist[i].idx == rs[3:0]) begin
        op = hist[i].d;
        f  = 1'b1;
        return;
      end
    end
  endfunction

  function automatic void m_reset();
    hist.delete();
    m_rs1 = '0;
    m_rs2 = '0;
    m_cnt = 0;
  endfunction

  function automatic void m_edge();
    logic [31:0] oa, ob;
    logic        fa, fb;
    ent_t        e;
    if (!rst_n || !clk_enable) return;
    m_pick(m_rs1, rf_data_a, oa, fa);
    m_pick(m_rs2, rf_data_b, ob, fb);
    if (cnt_clear) m_cnt = 0;
    else begin
      m_cnt = m_cnt + int'(fa) + int'(fb);
      if (m_cnt > 65535) m_cnt = 65535;
    end
    m_rs1 = rs1_sf;
    m_rs2 = rs2_sf;
    e.v   = wr_en_s3 && (rd_s3 != 5'd0);
    e.idx = rd_s3[3:0];
    e.d   = wr_data_s3;
    hist.push_front(e);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endfunction

  function automatic void check_model();
    logic [31:0] ea, eb;
    logic        fa, fb;
    m_pick(m_rs1, rf_data_a, ea, fa);
    m_pick(m_rs2, rf_data_b, eb, fb);
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("fwd_a", 32'(fwd_a), 32'(fa));
    chk("fwd_b", 32'(fwd_b), 32'(fb));
    chk("fwd_count", 32'(fwd_count), 32'(m_cnt));
  endfunction

  task automatic cycle();
    @(posedge clk);
    m_edge();
    #1;
    check_model();
  endtask

  function automatic logic [4:0] rand_reg();
    logic [4:0] r;
    if ($urandom_range(0, 1) == 1) r = 5'($urandom_range(0, 31));
    else r = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
    return r;
  endfunction

  task automatic rand_inputs();
    rs1_sf     = rand_reg();
    rs2_sf     = rand_reg();
    rd_s3      = rand_reg();
    wr_en_s3   = 1'($urandom_range(0, 3) != 0);
    wr_data_s3 = $urandom;
    rf_data_a  = $urandom;
    rf_data_b  = $urandom;
  endtask

  initial begin
    int guard;
    m_reset();

    // Asynchronous reset, no clock edge yet.
    rs1_sf    = 5'd5;
    rf_data_a = 32'hDEAD;
    #2 rst_n  = 1'b0;
    #1;
    chk("reset_op_a", op_a, 32'h0);
    chk("reset_fwd_a", 32'(fwd_a), 32'h0);
    chk("reset_count", 32'(fwd_count), 32'h0);
    check_model();
    @(negedge clk);
    rst_n  = 1'b1;
    rs1_sf = 5'd0;

    // Same-edge write/read hazard.
    rs1_sf = 5'd3; wr_en_s3 = 1'b1; rd_s3 = 5'd3; wr_data_s3 = 32'h1234; rf_data_a = 32'h0;
    cycle();
    chk("hazard_op_a", op_a, 32'h1234);
    chk("hazard_fwd_a", 32'(fwd_a), 32'h1);

    // x0 is never recorded and always reads zero.
    rs1_sf = 5'd0; rd_s3 = 5'd0; wr_data_s3 = 32'hFF;
    cycle();
    chk("x0_op_a", op_a, 32'h0);
    chk("x0_fwd_a", 32'(fwd_a), 32'h0);

    // x17 aliases x1 through the 4-bit index compare.
    rs2_sf = 5'd17; rd_s3 = 5'd1; wr_data_s3 = 32'h55; rf_data_b = 32'h77;
    cycle();
    chk("alias_op_b", op_b, 32'h55);
    chk("alias_fwd_b", 32'(fwd_b), 32'h1);

    // Youngest of two matching writes wins.
    rs2_sf = 5'd0; rd_s3 = 5'd4; wr_data_s3 = 32'hA;
    cycle();
    rs1_sf = 5'd4; wr_data_s3 = 32'hB;
    cycle();
    chk("youngest_op_a", op_a, 32'hB);

    // Stall: nothing advances even with busy inputs.
    wr_en_s3   = 1'b0;
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rs1_sf = rand_reg(); rs2_sf = rand_reg(); rd_s3 = rand_reg();
      wr_en_s3 = 1'b1; wr_data_s3 = $urandom; cnt_clear = 1'($urandom_range(0, 1));
      cycle();
      chk("stall_op_a", op_a, 32'hB);
      chk("stall_count", 32'(fwd_count), 32'd2);
    end
    clk_enable = 1'b1;
    cnt_clear  = 1'b0;

    // Drive both ports onto a freshly written x5 every cycle.
    rs1_sf = 5'd5; rs2_sf = 5'd5; rd_s3 = 5'd5; wr_en_s3 = 1'b1; wr_data_s3 = 32'hC0DE;
    cycle();
    cycle();
    cnt_clear = 1'b1;
    cycle();
    chk("clear_count", 32'(fwd_count), 32'h0);
    cnt_clear = 1'b0;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 40000) begin
      wr_data_s3 = $urandom;
      cycle();
      guard++;
    end
    chk("preload_count", 32'(fwd_count), 32'hFFFE);
    cycle();
    chk("sat_count", 32'(fwd_count), 32'hFFFF);
    cycle();
    chk("sat_hold_count", 32'(fwd_count), 32'hFFFF);
    cnt_clear = 1'b1;
    cycle();
    chk("clear_beats_inc", 32'(fwd_count), 32'h0);
    cnt_clear = 1'b0;

    // Randomized traffic with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_model();
        chk("midreset_op_a", op_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_enable = 1'b1; cnt_clear = 1'b0; wr_en_s3 = 1'b0;
        rs1_sf = 5'd7; rf_data_a = 32'h1111;
        cycle();
        chk("post_reset_op_a", op_a, 32'h1111);
        chk("post_reset_fwd_a", 32'(fwd_a), 32'h0);
      end
      rand_inputs();
      clk_enable = 1'($urandom_range(0, 4) != 0);
      cnt_clear  = 1'($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
